// File: rtl/uart_result_fmt.sv
// uart_result_fmt: formats one captured quotient/remainder pair as the ASCII
// line "Q=<hex> R=<hex>\r\n" and pushes it byte by byte into the UART
// transmitter FIFO. It stalls while the FIFO reports full.
module uart_result_fmt #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_tx,
    input  logic                  rst_clk_tx,
    input  logic [DATA_WIDTH-1:0] quotient,
    input  logic [DATA_WIDTH-1:0] remainder,
    input  logic                  result_valid,
    output logic                  result_ready,
    output logic [7:0]            tx_din,
    output logic                  write_en,
    input  logic                  tx_fifo_full,
    output logic                  busy
);

    localparam int N_DIGITS = DATA_WIDTH / 4;
    localparam int LINE_LEN = 2 * N_DIGITS + 7;
    localparam int IDX_W    = $clog2(LINE_LEN);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_s;
    logic                    capture_s;
    logic [DATA_WIDTH-1:0]   quot_r;
    logic [DATA_WIDTH-1:0]   rem_r;
    logic [7:0]              line_s [LINE_LEN];
    logic                    push_s;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        logic [7:0] code;
        if (nib < 4'd10) begin
            code = 8'h30 + {4'h0, nib};
        end else begin
            code = 8'h37 + {4'h0, nib};
        end
        return code;
    endfunction

    // Assemble the full output line from the captured fields; digits MSB first.
    always_comb begin
        for (int i = 0; i < LINE_LEN; i++) begin
            line_s[i] = 8'h00;
        end
        line_s[0] = 8'h51;
        line_s[1] = 8'h3D;
        for (int d = 0; d < N_DIGITS; d++) begin
            line_s[2 + d]            = nib_to_ascii(quot_r[4*(N_DIGITS-1-d) +: 4]);
            line_s[N_DIGITS + 5 + d] = nib_to_ascii(rem_r[4*(N_DIGITS-1-d) +: 4]);
        end
        line_s[N_DIGITS + 2]     = 8'h20;
        line_s[N_DIGITS + 3]     = 8'h52;
        line_s[N_DIGITS + 4]     = 8'h3D;
        line_s[2 * N_DIGITS + 5] = 8'h0D;
        line_s[2 * N_DIGITS + 6] = 8'h0A;
    end

    // Handshake and FIFO outputs; only tx_fifo_full reaches an output combinationally.
    always_comb begin
        result_ready = 1'b0;
        busy         = 1'b0;
        push_s       = 1'b0;
        tx_din       = 8'h00;
        if (state_r == ST_SEND) begin
            busy   = 1'b1;
            push_s = ~tx_fifo_full;
            tx_din = line_s[idx_r];
        end else begin
            result_ready = 1'b1;
        end
        write_en = push_s;
    end

    // Next state and byte index: accept in IDLE, advance on each push in SEND.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (result_valid) begin
                    state_s   = ST_SEND;
                    idx_s     = IDX_ZERO;
                    capture_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (push_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_IDLE;
                        idx_s   = IDX_ZERO;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = IDX_ZERO;
            end
        endcase
    end

    // State, index and captured operands; reset abandons any partial line.
    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
            quot_r  <= {DATA_WIDTH{1'b0}};
            rem_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if (capture_s) begin
                quot_r <= quotient;
                rem_r  <= remainder;
            end
        end
    end

endmodule

// File: tb/tb_uart_result_fmt.sv
// Bench for uart_result_fmt: a queue of expected line bytes is the reference;
// it is compared against the 16-bit DUT every cycle, plus directed cases and a
// 32-bit instance checked against a literal line.
module tb_uart_result_fmt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] quotient = 16'h0000;
    logic [15:0] remainder = 16'h0000;
    logic        result_valid = 1'b0;
    logic        tx_fifo_full = 1'b0;
    logic        result_ready;
    logic [7:0]  tx_din;
    logic        write_en;
    logic        busy;

    logic [31:0] q32 = 32'h0;
    logic [31:0] r32 = 32'h0;
    logic        v32 = 1'b0;
    logic        full32 = 1'b0;
    logic        ready32;
    logic [7:0]  din32;
    logic        we32;
    logic        busy32;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cnt = 0;
    int accept_cyc[$];
    logic [7:0] exp_q[$];
    logic [7:0] got16[$];
    logic [7:0] got32[$];
    int lat;

    always #5 clk = ~clk;

    uart_result_fmt #(.DATA_WIDTH(16)) dut (
        .clk_tx(clk), .rst_clk_tx(rst), .quotient(quotient), .remainder(remainder),
        .result_valid(result_valid), .result_ready(result_ready), .tx_din(tx_din),
        .write_en(write_en), .tx_fifo_full(tx_fifo_full), .busy(busy)
    );

    uart_result_fmt #(.DATA_WIDTH(32)) dut32 (
        .clk_tx(clk), .rst_clk_tx(rst), .quotient(q32), .remainder(r32),
        .result_valid(v32), .result_ready(ready32), .tx_din(din32),
        .write_en(we32), .tx_fifo_full(full32), .busy(busy32)
    );

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected 16-bit line built from formatted text.
    function automatic logic [119:0] line16(input logic [15:0] q, input logic [15:0] r);
        string s;
        logic [119:0] v;
        s = $sformatf("Q=%h R=%h", q, r);
        s = s.toupper();
        v = '0;
        for (int i = 0; i < 13; i++) v[119-8*i -: 8] = s[i];
        v[15:8] = 8'h0D;
        v[7:0]  = 8'h0A;
        return v;
    endfunction

    function automatic void push_line(input logic [15:0] q, input logic [15:0] r);
        logic [119:0] v;
        v = line16(q, r);
        for (int i = 0; i < 15; i++) exp_q.push_back(v[119-8*i -: 8]);
    endfunction

    function automatic logic [119:0] pack16(input int base);
        logic [119:0] v;
        v = '0;
        for (int i = 0; i < 15; i++)
            v[119-8*i -: 8] = (base + i < got16.size()) ? got16[base+i] : 8'h00;
        return v;
    endfunction

    function automatic logic [183:0] pack32();
        logic [183:0] v;
        v = '0;
        for (int i = 0; i < 23; i++)
            v[183-8*i -: 8] = (i < got32.size()) ? got32[i] : 8'h00;
        return v;
    endfunction

    // Reference: pending bytes leave one per non-full edge; accept only when empty.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (exp_q.size() != 0) begin
                if (!tx_fifo_full) void'(exp_q.pop_front());
            end else if (result_valid) begin
                push_line(quotient, remainder);
                accept_cyc.push_back(cyc);
                accept_cnt <= accept_cnt + 1;
            end
        end
    end

    // Per-cycle comparison of the 16-bit DUT against the reference.
    always @(negedge clk) begin
        check("ready", 192'(result_ready), 192'(exp_q.size() == 0));
        check("busy", 192'(busy), 192'(exp_q.size() != 0));
        check("write_en", 192'(write_en), 192'((exp_q.size() != 0) && !tx_fifo_full));
        check("tx_din", 192'(tx_din), 192'((exp_q.size() != 0) ? exp_q[0] : 8'h00));
    end

    // Record bytes actually pushed by both DUTs.
    always @(posedge clk) begin
        if (!rst && write_en) got16.push_back(tx_din);
        if (!rst && we32) got32.push_back(din32);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer16(input logic [15:0] q, input logic [15:0] r, input bit keep);
        int start;
        int n;
        start = accept_cnt;
        n = 0;
        quotient = q;
        remainder = r;
        result_valid = 1'b1;
        while (accept_cnt == start && n < 100) begin
            tick();
            n++;
        end
        check("accept_timeout", 192'(n < 100), 192'(1'b1));
        if (!keep) result_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("idle_timeout", 192'(n < 300), 192'(1'b1));
        tick();
    endtask

    task automatic ready_latency(output int l);
        int n;
        n = 0;
        while (!result_ready && n < 100) begin
            tick();
            n++;
        end
        l = cyc - accept_cyc[$];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 192'(result_ready), 192'(1'b1));
        check("rst_busy", 192'(busy), 192'(1'b0));
        check("rst_we", 192'(write_en), 192'(1'b0));
        check("rst_din", 192'(tx_din), 192'(8'h00));
        check("rst_ready32", 192'(ready32), 192'(1'b1));
        check("rst_we32", 192'(we32), 192'(1'b0));
        rst = 1'b0;

        // Pin the reference line builder with hand-computed lines.
        check("pin_1234", 192'(line16(16'h1234, 16'h00AF)), 192'(120'h513D3132333420523D303041460D0A));
        check("pin_ffff", 192'(line16(16'hFFFF, 16'h0000)), 192'(120'h513D4646464620523D303030300D0A));
        check("pin_9a0b", 192'(line16(16'h9A0B, 16'hC0DE)), 192'(120'h513D3941304220523D433044450D0A));
        tick();

        // Basic line.
        got16.delete();
        offer16(16'h1234, 16'h00AF, 1'b0);
        ready_latency(lat);
        check("basic_latency", 192'(lat), 192'(16));
        check("basic_count", 192'(got16.size()), 192'(15));
        check("basic_line", 192'(pack16(0)), 192'(120'h513D3132333420523D303041460D0A));
        tick();

        // Digit extremes.
        got16.delete();
        offer16(16'hFFFF, 16'h0000, 1'b0);
        wait_idle();
        check("ffff_line", 192'(pack16(0)), 192'(120'h513D4646464620523D303030300D0A));
        got16.delete();
        offer16(16'h9A0B, 16'hC0DE, 1'b0);
        wait_idle();
        check("9a0b_line", 192'(pack16(0)), 192'(120'h513D3941304220523D433044450D0A));

        // Back-pressure for 5 cycles while byte 6 (space) is presented.
        got16.delete();
        offer16(16'h1234, 16'h00AF, 1'b0);
        repeat (6) tick();
        tx_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_we", 192'(write_en), 192'(1'b0));
            check("bp_din", 192'(tx_din), 192'(8'h20));
            tick();
        end
        tx_fifo_full = 1'b0;
        ready_latency(lat);
        check("bp_latency", 192'(lat), 192'(21));
        check("bp_count", 192'(got16.size()), 192'(15));
        check("bp_line", 192'(pack16(0)), 192'(120'h513D3132333420523D303041460D0A));
        tick();

        // Back-to-back with valid held and data changing mid-line.
        got16.delete();
        offer16(16'h1111, 16'h2222, 1'b1);
        repeat (4) tick();
        offer16(16'hBEEF, 16'h0042, 1'b0);
        check("b2b_gap", 192'(accept_cyc[$] - accept_cyc[$-1]), 192'(16));
        wait_idle();
        check("b2b_count", 192'(got16.size()), 192'(30));
        check("b2b_line1", 192'(pack16(0)), 192'(120'h513D3131313120523D323232320D0A));
        check("b2b_line2", 192'(pack16(15)), 192'(120'h513D4245454620523D303034320D0A));

        // Asynchronous reset after byte 7.
        offer16(16'h5555, 16'hAAAA, 1'b0);
        repeat (8) tick();
        got16.delete();
        #1;
        rst = 1'b1;
        #1;
        check("mrst_we", 192'(write_en), 192'(1'b0));
        check("mrst_ready", 192'(result_ready), 192'(1'b1));
        check("mrst_busy", 192'(busy), 192'(1'b0));
        check("mrst_din", 192'(tx_din), 192'(8'h00));
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("mrst_nowrite", 192'(got16.size()), 192'(0));
        offer16(16'h0F0F, 16'h7E81, 1'b0);
        ready_latency(lat);
        check("mrst_latency", 192'(lat), 192'(16));
        check("mrst_line", 192'(pack16(0)), 192'(120'h513D3046304620523D374538310D0A));
        tick();

        // 32-bit instance.
        got32.delete();
        q32 = 32'hDEADBEEF;
        r32 = 32'h00000001;
        v32 = 1'b1;
        tick();
        v32 = 1'b0;
        repeat (30) tick();
        check("w32_count", 192'(got32.size()), 192'(23));
        check("w32_line", 192'(pack32()),
              192'(184'h513D444541444245454620523D30303030303030310D0A));

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 2000; c++) begin
            result_valid = 1'($urandom_range(0, 1));
            quotient     = 16'($urandom);
            remainder    = 16'($urandom);
            tx_fifo_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        result_valid = 1'b0;
        tx_fifo_full = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
